// File: rtl/alu_multiciclo.sv
// alu_multiciclo: handshaked ALU with single-cycle logic/arith/shift ops and
// iterative shift-add multiply and restoring unsigned divide/remainder.
module alu_multiciclo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SEL_W-1:0] selOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             zeroFlag,
    output logic             overflowFlag,
    output logic             divZeroFlag
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(4'b0000);
    localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(4'b0001);
    localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(4'b0010);
    localparam logic [SEL_W-1:0] OP_SLL  = SEL_W'(4'b0011);
    localparam logic [SEL_W-1:0] OP_SRL  = SEL_W'(4'b0100);
    localparam logic [SEL_W-1:0] OP_SRA  = SEL_W'(4'b0101);
    localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(4'b0110);
    localparam logic [SEL_W-1:0] OP_SLT  = SEL_W'(4'b0111);
    localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(4'b1000);
    localparam logic [SEL_W-1:0] OP_DIVU = SEL_W'(4'b1001);
    localparam logic [SEL_W-1:0] OP_REMU = SEL_W'(4'b1010);
    localparam logic [SEL_W-1:0] OP_NOR  = SEL_W'(4'b1100);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   op_q;
    logic [WIDTH-1:0]   a_q;     // MUL: multiplicand; DIV: dividend shifting into quotient
    logic [WIDTH-1:0]   b_q;     // MUL: multiplier;   DIV: divisor
    logic [WIDTH-1:0]   acc_q;   // MUL: product;      DIV: partial remainder

    logic [WIDTH-1:0]   a_n;
    logic [WIDTH-1:0]   b_n;
    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   fin_c;

    logic [WIDTH-1:0]   res_c;
    logic [WIDTH-1:0]   sum_c;
    logic [WIDTH-1:0]   dif_c;
    logic               ovf_c;
    logic               dz_c;
    logic               iter_c;
    logic [SH_W-1:0]    sh_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (in_valid) state_n = iter_c ? CALC : DONE;
            CALC: if (cnt_q == '0) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Single-cycle result, flags, and whether the op needs the iterative engine
    always_comb begin
        sh_c   = op2[SH_W-1:0];
        sum_c  = op1 + op2;
        dif_c  = op1 - op2;
        res_c  = '0;
        ovf_c  = 1'b0;
        dz_c   = 1'b0;
        iter_c = 1'b0;
        case (selOp)
            OP_AND: res_c = op1 & op2;
            OP_OR:  res_c = op1 | op2;
            OP_NOR: res_c = ~(op1 | op2);
            OP_ADD: begin
                res_c = sum_c;
                ovf_c = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_c[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = dif_c;
                ovf_c = (op1[WIDTH-1] != op2[WIDTH-1]) && (dif_c[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SLT: res_c = WIDTH'(op1 < op2);
            OP_SLL: res_c = op1 << sh_c;
            OP_SRL: res_c = op1 >> sh_c;
            OP_SRA: res_c = WIDTH'($signed(op1) >>> sh_c);
            OP_MUL: iter_c = 1'b1;
            OP_DIVU, OP_REMU: begin
                // Divide by zero resolves immediately without iterating
                if (op2 == '0) begin
                    dz_c  = 1'b1;
                    res_c = (selOp == OP_DIVU) ? '1 : op1;
                end else begin
                    iter_c = 1'b1;
                end
            end
            default: res_c = '0;
        endcase
    end

    // One shift-add or restoring shift-subtract step of the iterative engine
    always_comb begin
        a_n      = a_q;
        b_n      = b_q;
        acc_n    = acc_q;
        rem_sh   = '0;
        rem_diff = '0;
        fin_c    = '0;
        if (op_q == OP_MUL) begin
            acc_n = b_q[0] ? (acc_q + a_q) : acc_q;
            a_n   = a_q << 1;
            b_n   = b_q >> 1;
            fin_c = acc_n;
        end else begin
            rem_sh   = {acc_q, a_q[WIDTH-1]};
            rem_diff = rem_sh - {1'b0, b_q};
            if (!rem_diff[WIDTH]) begin
                acc_n = rem_diff[WIDTH-1:0];
                a_n   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                a_n   = {a_q[WIDTH-2:0], 1'b0};
            end
            fin_c = (op_q == OP_REMU) ? acc_n : a_n;
        end
    end

    // Operand latch, iteration datapath and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            resultado    <= '0;
            zeroFlag     <= 1'b0;
            overflowFlag <= 1'b0;
            divZeroFlag  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (iter_c) begin
                            op_q  <= selOp;
                            a_q   <= op1;
                            b_q   <= op2;
                            acc_q <= '0;
                            cnt_q <= CNT_W'(WIDTH - 1);
                        end else begin
                            resultado    <= res_c;
                            zeroFlag     <= (res_c == '0);
                            overflowFlag <= ovf_c;
                            divZeroFlag  <= dz_c;
                        end
                    end
                end
                CALC: begin
                    a_q   <= a_n;
                    b_q   <= b_n;
                    acc_q <= acc_n;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        resultado    <= fin_c;
                        zeroFlag     <= (fin_c == '0);
                        overflowFlag <= 1'b0;
                        divZeroFlag  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed self-checking bench for alu_multiciclo (WIDTH=32).
module tb_alu_multiciclo;

    localparam int unsigned W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [3:0]   selOp;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] resultado;
    logic         zeroFlag;
    logic         overflowFlag;
    logic         divZeroFlag;

    int ntest = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    alu_multiciclo #(.WIDTH(W), .SEL_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op1          (op1),
        .op2          (op2),
        .selOp        (selOp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .resultado    (resultado),
        .zeroFlag     (zeroFlag),
        .overflowFlag (overflowFlag),
        .divZeroFlag  (divZeroFlag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntest++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready high, wait for out_valid, check result, flags and latency
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic ez,
                          input logic eo, input logic ed, input int elat);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        selOp     = op;
        op1       = a;
        op2       = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".res"}, resultado, exp_r);
        check({tag, ".zero"}, 32'(zeroFlag), 32'(ez));
        check({tag, ".ovf"}, 32'(overflowFlag), 32'(eo));
        check({tag, ".dz"}, 32'(divZeroFlag), 32'(ed));
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        @(negedge clk);
        check({tag, ".vdrop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op1       = '0;
        op2       = '0;
        selOp     = '0;

        // Reset state
        #12;
        check("rst.res", resultado, 32'h0);
        check("rst.ovalid", 32'(out_valid), 32'd0);
        check("rst.flags", {29'd0, zeroFlag, overflowFlag, divZeroFlag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops
        run_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
        run_op("sub_zero", OP_SUB, 32'd5,         32'd5,          32'h0,         1'b1, 1'b0, 1'b0, 1);
        run_op("slt",      OP_SLT, 32'd3,         32'hFFFF_FFFF,  32'h1,         1'b0, 1'b0, 1'b0, 1);
        run_op("sra",      OP_SRA, 32'h8000_0000, 32'd4,          32'hF800_0000, 1'b0, 1'b0, 1'b0, 1);
        run_op("sra_mask", OP_SRA, 32'h8000_0000, 32'h24,         32'hF800_0000, 1'b0, 1'b0, 1'b0, 1);
        run_op("sll31",    OP_SLL, 32'h1,         32'd31,         32'h8000_0000, 1'b0, 1'b0, 1'b0, 1);
        run_op("srl31",    OP_SRL, 32'h8000_0000, 32'd31,         32'h1,         1'b0, 1'b0, 1'b0, 1);
        run_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
        run_op("nor",      OP_NOR, 32'h0,         32'h0,          32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1);
        run_op("badop",    OP_BAD, 32'h1234,      32'h5678,       32'h0,         1'b1, 1'b0, 1'b0, 1);

        // Iterative multiply / divide
        run_op("mul",      OP_MUL,  32'h0001_0003, 32'h10,        32'h0010_0030, 1'b0, 1'b0, 1'b0, 33);
        run_op("mul_ff",   OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 33);
        run_op("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0, 33);
        run_op("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0, 33);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33);
        run_op("divu_z",   OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1);
        run_op("remu_z",   OP_REMU, 32'd9,         32'd0,         32'd9,         1'b0, 1'b0, 1'b1, 1);

        // Back-pressure after MUL with a competing in_valid
        @(negedge clk);
        selOp     = OP_MUL;
        op1       = 32'd6;
        op2       = 32'd7;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp.lat", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            selOp    = OP_AND;
            op1      = 32'hFF;
            op2      = 32'h0F;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp.hold_res", resultado, 32'd42);
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.xfer_valid", 32'(out_valid), 32'd0);
        check("bp.xfer_in_ready", 32'(in_ready), 32'd1);
        check("bp.xfer_res", resultado, 32'd42);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.next_valid", 32'(out_valid), 32'd1);
        check("bp.next_res", resultado, 32'h0F);
        @(negedge clk);
        check("bp.next_drop", 32'(out_valid), 32'd0);

        // Reset in the middle of a divide
        selOp     = OP_DIVU;
        op1       = 32'd1000;
        op2       = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort.pre_res", resultado, 32'h0F);
        check("abort.pre_valid", 32'(out_valid), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.res", resultado, 32'h0);
        check("abort.valid", 32'(out_valid), 32'd0);
        check("abort.flags", {29'd0, zeroFlag, overflowFlag, divZeroFlag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_and", OP_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
